// File: rtl/param_rom_stream_arbiter_pkg.sv
// Shared types and helpers for the parameter-ROM stream arbiter.
package param_rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } arb_state_t;

   // Widest requester vector rr_pick can scan; NUM_REQ must not exceed it.
   localparam int MAX_REQ = 32;

   // One slot more than the ROM pipeline keeps a full-rate stream bubble-free.
   function automatic int fifo_depth(input int rom_latency);
      return rom_latency + 1;
   endfunction

   // Index of the first set request at or after ptr, wrapping modulo n.
   function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned pick;
      int unsigned idx;
      logic        found;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = (ptr + i) % n;
         if ((i < n) && !found && (((req_vec >> idx) & MAX_REQ'(1)) != '0)) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/param_rom_stream_arbiter_if.sv
// Consumer and ROM-side signal bundle of the parameter-ROM stream arbiter.
interface param_rom_stream_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    grant;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic                  rom_ce;
   logic [DATA_WIDTH-1:0] rom_q;
   logic [DATA_WIDTH-1:0] data_out;
   logic [NUM_REQ-1:0]    data_out_valid;
   logic [NUM_REQ-1:0]    data_out_ready;
   logic [NUM_REQ-1:0]    done;

   modport master (
      input  req, rom_q, data_out_ready,
      output grant, rom_addr, rom_ce, data_out, data_out_valid, done
   );

   modport slave (
      output req, rom_q, data_out_ready,
      input  grant, rom_addr, rom_ce, data_out, data_out_valid, done
   );
endinterface

// File: rtl/param_rom_stream_arbiter_skid_fifo.sv
// Small synchronous FIFO absorbing ROM read latency; head reads as zero when empty.
module param_rom_skid_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 3,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [CNT_W-1:0]      count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/param_rom_stream_arbiter.sv
// Round-robin arbiter streaming whole tensors from one shared parameter ROM.
// Optional macro PARAM_ROM_ARB_PERF_EN adds a saturating stall_cycles counter.
module param_rom_stream_arbiter
   import param_rom_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int OUT_DEPTH   = 32,
   parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1,
   parameter int ROM_LATENCY = 2
) (
   input  logic clk,
   input  logic rst,
   param_rom_stream_arbiter_if.master bus
`ifdef PARAM_ROM_ARB_PERF_EN
   ,
   output logic [31:0] stall_cycles
`endif
);
   localparam int FIFO_DEPTH = fifo_depth(ROM_LATENCY);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CRD_W      = $clog2(ROM_LATENCY + FIFO_DEPTH + 2);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(OUT_DEPTH - 1);

   arb_state_t             state;
   arb_state_t             state_nxt;
   logic [NUM_REQ-1:0]     grant;
   logic [NUM_REQ-1:0]     done;
   logic [NUM_REQ-1:0]     valid;
   logic [PTR_W-1:0]       grant_idx;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       pick_idx;
   logic [ADDR_WIDTH-1:0]  addr_cnt;
   logic [ADDR_WIDTH-1:0]  word_cnt;
   logic [ROM_LATENCY-1:0] inflight;
   logic [CRD_W-1:0]       inflight_cnt;
   logic [CNT_W-1:0]       fifo_count;
   logic [DATA_WIDTH-1:0]  fifo_head;
   logic                   pop;
   logic                   credit_ok;
   logic                   issue;
   logic                   start;
   logic                   finish;

   assign pick_idx = PTR_W'(rr_pick(MAX_REQ'(bus.req), 32'(rr_ptr), NUM_REQ));

   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < ROM_LATENCY; i++) inflight_cnt = inflight_cnt + CRD_W'(inflight[i]);
   end

   assign valid = grant & {NUM_REQ{fifo_count != '0}};
   assign pop   = |(valid & bus.data_out_ready);

   // A pop this cycle frees a slot, so the credit check adds it back.
   assign credit_ok = (inflight_cnt + CRD_W'(fifo_count)) < (CRD_W'(FIFO_DEPTH) + CRD_W'(pop));

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      start     = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               start     = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            issue = credit_ok;
            if (credit_ok && (addr_cnt == LAST)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop && (word_cnt == LAST)) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
         addr_cnt  <= '0;
         word_cnt  <= '0;
         inflight  <= '0;
         done      <= '0;
      end else begin
         done     <= '0;
         inflight <= (inflight << 1) | ROM_LATENCY'(issue);
         if (issue) addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
         if (pop)   word_cnt <= word_cnt + ADDR_WIDTH'(1);
         if (start) begin
            grant     <= NUM_REQ'(1) << pick_idx;
            grant_idx <= pick_idx;
            addr_cnt  <= '0;
            word_cnt  <= '0;
         end
         if (finish) begin
            done     <= NUM_REQ'(1) << grant_idx;
            grant    <= '0;
            rr_ptr   <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            addr_cnt <= '0;
            word_cnt <= '0;
         end
      end
   end

   // ROM tail of the valid shift register marks rom_q as a real word.
   param_rom_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight[ROM_LATENCY-1]),
      .pop   (pop),
      .din   (bus.rom_q),
      .dout  (fifo_head),
      .count (fifo_count)
   );

   assign bus.grant          = grant;
   assign bus.done           = done;
   assign bus.data_out_valid = valid;
   assign bus.data_out       = fifo_head;
   assign bus.rom_addr       = addr_cnt;
   assign bus.rom_ce         = rst;

`ifdef PARAM_ROM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if ((state != IDLE) && ((valid & ~bus.data_out_ready) != '0) &&
                   (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_param_rom_stream_arbiter.sv
// Scoreboard bench for param_rom_stream_arbiter with a 2-stage ROM holding addr+0x100.
module tb_param_rom_stream_arbiter;
   localparam int NREQ  = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 3;

   typedef struct packed {
      logic [NREQ-1:0] port;
      logic [DW-1:0]   data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   param_rom_stream_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef PARAM_ROM_ARB_PERF_EN
   logic [31:0] stall_cycles;
`endif

   param_rom_stream_arbiter #(
      .NUM_REQ     (NREQ),
      .DATA_WIDTH  (DW),
      .OUT_DEPTH   (DEPTH),
      .ADDR_WIDTH  (AW),
      .ROM_LATENCY (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PARAM_ROM_ARB_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   // ROM model: registered address stage then registered data stage.
   logic [AW-1:0] rom_s1;
   logic [DW-1:0] rom_q_r;
   always @(posedge clk) begin
      if (bus.rom_ce) begin
         rom_s1  <= bus.rom_addr;
         rom_q_r <= 32'h100 + DW'(rom_s1);
      end
   end
   assign bus.rom_q = rom_q_r;

   int checks  = 0;
   int errors  = 0;
   int max_cnt = 0;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_stream(input logic [NREQ-1:0] port, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.port = port;
         e.data = DW'(32'h100 + i);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_grant(input int limit, output logic [NREQ-1:0] g);
      g = '0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.grant != '0) begin
            g = bus.grant;
            break;
         end
      end
      if (g == '0) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: got no grant in %0d cycles, required one", limit);
      end
   endtask

   task automatic wait_done(input int limit, output logic [NREQ-1:0] d);
      d = '0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.done != '0) begin
            d = bus.done;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Monitor: every accepted word is popped from the scoreboard and compared.
   logic [NREQ-1:0] hs;
   exp_t            mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
         hs = bus.data_out_valid & bus.data_out_ready;
         if (hs != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got port %b data 0x%0h, required no word", hs, bus.data_out);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_port", 64'(hs), 64'(mon_e.port));
               chk("sb_data", 64'(bus.data_out), 64'(mon_e.data));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded time limit, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   logic [NREQ-1:0] g;
   logic [NREQ-1:0] d;
   logic [NREQ-1:0] exp_g [3];
   logic [NREQ-1:0] pat   [4];
   int first_v;
   int done_k;
   int n_acc;

   initial begin
      exp_g = '{2'b01, 2'b10, 2'b01};
      pat   = '{2'b11, 2'b00, 2'b00, 2'b11};
      bus.req            = '0;
      bus.data_out_ready = '1;
      rst                = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant",    64'(bus.grant), 64'(0));
      chk("rst_valid",    64'(bus.data_out_valid), 64'(0));
      chk("rst_done",     64'(bus.done), 64'(0));
      chk("rst_rom_addr", 64'(bus.rom_addr), 64'(0));
      chk("rst_data_out", 64'(bus.data_out), 64'(0));
      chk("rst_rom_ce",   64'(bus.rom_ce), 64'(0));
      @(posedge clk);
      #1 rst = 1'b1;

      // Single stream, ready high: latency and throughput.
      push_stream(2'b01, DEPTH);
      @(posedge clk);
      #1 bus.req = 2'b01;
      @(negedge clk);
      chk("t1_grant_t0", 64'(bus.grant), 64'(0));
      @(negedge clk);
      chk("t1_grant_t1", 64'(bus.grant), 64'(2'b01));
      chk("t1_addr_t1",  64'(bus.rom_addr), 64'(0));
      chk("t1_rom_ce",   64'(bus.rom_ce), 64'(1));
      first_v = -1;
      done_k  = -1;
      for (int k = 2; k <= 20; k++) begin
         @(negedge clk);
         if (k == 3) chk("t1_rom_q_t3", 64'(bus.rom_q), 64'(32'h100));
         if (first_v < 0 && bus.data_out_valid != '0) first_v = k;
         if (bus.done != '0) begin
            done_k = k;
            break;
         end
      end
      chk("t1_first_valid_cycle", 64'(first_v), 64'(4));
      chk("t1_done_cycle",        64'(done_k), 64'(8));
      chk("t1_done_port",         64'(bus.done), 64'(2'b01));
      chk("t1_grant_cleared",     64'(bus.grant), 64'(0));
      bus.req = '0;

      // Both requesting from rr_ptr=0: grants alternate 01, 10, 01.
      do_reset();
      push_stream(2'b01, DEPTH);
      push_stream(2'b10, DEPTH);
      push_stream(2'b01, DEPTH);
      @(posedge clk);
      #1 bus.req = 2'b11;
      wait_grant(20, g);
      chk("rr_grant0", 64'(g), 64'(exp_g[0]));
      for (int s = 0; s < 3; s++) begin
         wait_done(40, d);
         chk("rr_done", 64'(d), 64'(exp_g[s]));
         chk("rr_grant_clr", 64'(bus.grant), 64'(0));
         if (s == 2) begin
            bus.req = '0;
         end else begin
            @(negedge clk);
            chk("rr_next_grant", 64'(bus.grant), 64'(exp_g[s+1]));
         end
      end

      // Ready pattern 1,0,0,1 repeating.
      push_stream(2'b01, DEPTH);
      @(posedge clk);
      #1 bus.req = 2'b01;
      d = '0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (bus.done != '0) begin
            d = bus.done;
            bus.req = '0;
            break;
         end
         bus.data_out_ready = pat[i % 4];
      end
      bus.data_out_ready = '1;
      chk("t3_done", 64'(d), 64'(2'b01));

      // Ready held low: buffer fills to FIFO depth and issue stalls.
      bus.data_out_ready = '0;
      push_stream(2'b01, DEPTH);
      @(posedge clk);
      #1 bus.req = 2'b01;
      wait_grant(20, g);
      repeat (10) @(negedge clk);
      chk("t4_fifo_count", 64'(dut.u_fifo.count), 64'(3));
      chk("t4_valid",      64'(bus.data_out_valid), 64'(2'b01));
      chk("t4_head",       64'(bus.data_out), 64'(32'h100));
      chk("t4_issue_halt", 64'(bus.rom_addr), 64'(3));
      @(posedge clk);
      #1 bus.data_out_ready = '1;
      wait_done(40, d);
      chk("t4_done", 64'(d), 64'(2'b01));
      bus.req = '0;

      // Reset after word 1 is accepted, then restart from address 0.
      push_stream(2'b01, 2);
      @(posedge clk);
      #1 bus.req = 2'b01;
      wait_grant(20, g);
      n_acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((bus.data_out_valid & bus.data_out_ready) != '0) n_acc++;
         if (n_acc == 2) break;
      end
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rst_grant", 64'(bus.grant), 64'(0));
      chk("t5_rst_valid", 64'(bus.data_out_valid), 64'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      push_stream(2'b01, DEPTH);
      wait_grant(20, g);
      chk("t5_restart_grant", 64'(g), 64'(2'b01));
      chk("t5_restart_addr",  64'(bus.rom_addr), 64'(0));
      wait_done(40, d);
      chk("t5_done", 64'(d), 64'(2'b01));
      bus.req = '0;

`ifdef PARAM_ROM_ARB_PERF_EN
      do_reset();
      @(negedge clk);
      chk("perf_rst", 64'(stall_cycles), 64'(0));
      bus.data_out_ready = '0;
      push_stream(2'b01, DEPTH);
      @(posedge clk);
      #1 bus.req = 2'b01;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.data_out_valid != '0) break;
      end
      repeat (5) @(posedge clk);
      #1 bus.data_out_ready = '1;
      @(negedge clk);
      chk("perf_stall5", 64'(stall_cycles), 64'(5));
      wait_done(40, d);
      bus.req = '0;
      chk("perf_stall_hold", 64'(stall_cycles), 64'(5));
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(exp_q.size()), 64'(0));
      chk("fifo_max", 64'(max_cnt), 64'(3));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
